// File: rtl/enc_quad_gen_pkg.sv
// Shared definitions for the quadrature encoder signal generator.
// Provides FSM state encodings, the {A,B} Gray phase constants and the
// default parameter values used by enc_quad_gen and enc_gen_phase.
package enc_quad_gen_pkg;

  localparam int unsigned DEF_CNT_W      = 24;
  localparam int unsigned DEF_PER_W      = 16;
  localparam int unsigned DEF_MIN_PERIOD = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Phase is {A,B}; forward order is PH_00 -> PH_10 -> PH_11 -> PH_01.
  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_10 = 2'b10;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_01 = 2'b01;

endpackage

// File: rtl/enc_gen_phase.sv
// Single-channel quadrature phase stepper.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   step         : advance the phase by one quadrature step this cycle
//   dir          : 1 = forward (A leads B), 0 = reverse
//   phase_nxt_c  : Gray phase that will be registered on this edge
//   enc_a, enc_b : registered quadrature outputs
module enc_gen_phase
  import enc_quad_gen_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   step,
  input  logic   dir,
  output phase_t phase_nxt_c,
  output logic   enc_a,
  output logic   enc_b
);

  phase_t phase;

  // Next Gray phase: exactly one of A/B toggles per step.
  always_comb begin
    phase_nxt_c = phase;
    if (step) begin
      case (phase)
        PH_00:   phase_nxt_c = dir ? PH_10 : PH_01;
        PH_10:   phase_nxt_c = dir ? PH_11 : PH_00;
        PH_11:   phase_nxt_c = dir ? PH_01 : PH_10;
        default: phase_nxt_c = dir ? PH_00 : PH_11;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= PH_00;
    end else begin
      phase <= phase_nxt_c;
    end
  end

  assign enc_a = phase[1];
  assign enc_b = phase[0];

endmodule

// File: rtl/enc_quad_gen.sv
// Quadrature encoder signal generator (A/B/index transmit side).
// Accepts signed move commands over valid/ready, emits quadrature steps
// at a clamped period and tracks its own position count.
// Optional feature macro: ENC_GEN_ABORT_EN (enables cmd_abort in RUN).
// Ports:
//   sysclk, reset            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready      : move command handshake
//   cmd_steps, cmd_period    : signed step count, sysclk cycles per step
//   index_cpr                : steps per index revolution (0 = no index)
//   preload_wen, preload_val : load the position counter
//   cmd_abort                : stop current move (only with the macro)
//   enc_a, enc_b, enc_i      : registered quadrature and index outputs
//   busy, done               : move in progress, completion pulse
//   position                 : generated position count
module enc_quad_gen
  import enc_quad_gen_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned PER_W      = DEF_PER_W,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [PER_W-1:0] cmd_period,
  input  logic [CNT_W-1:0] index_cpr,
  input  logic             preload_wen,
  input  logic [CNT_W-1:0] preload_val,
  input  logic             cmd_abort,
  output logic             enc_a,
  output logic             enc_b,
  output logic             enc_i,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] position
);

  state_e           state, state_nxt;
  logic [PER_W-1:0] timer, timer_nxt;
  logic [PER_W-1:0] period_q, period_nxt, period_eff_c;
  logic [CNT_W-1:0] steps_rem, steps_rem_nxt, steps_abs_c;
  logic [CNT_W-1:0] position_nxt;
  logic             dir_q, dir_nxt;
  logic             step_c, abort_c;
  logic             cmd_ready_nxt, busy_nxt, done_nxt, enc_i_nxt;
  phase_t           phase_nxt;

`ifdef ENC_GEN_ABORT_EN
  assign abort_c = cmd_abort;
`else
  logic unused_abort;
  assign unused_abort = cmd_abort;
  assign abort_c      = 1'b0;
`endif

  // Command decode: clamp period, take magnitude of the two's complement count.
  assign period_eff_c = (cmd_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : cmd_period;
  assign steps_abs_c  = cmd_steps[CNT_W-1] ? (~cmd_steps + CNT_W'(1)) : cmd_steps;
  assign step_c       = (state == RUN) && (timer == PER_W'(1));

  enc_gen_phase u_phase (
    .clk         (sysclk),
    .reset       (reset),
    .step        (step_c),
    .dir         (dir_q),
    .phase_nxt_c (phase_nxt),
    .enc_a       (enc_a),
    .enc_b       (enc_b)
  );

  // Next-state, timer and handshake outputs.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    period_nxt    = period_q;
    steps_rem_nxt = steps_rem;
    dir_nxt       = dir_q;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          period_nxt    = period_eff_c;
          timer_nxt     = period_eff_c;
          steps_rem_nxt = steps_abs_c;
          dir_nxt       = ~cmd_steps[CNT_W-1];
          state_nxt     = (steps_abs_c == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (step_c) begin
          timer_nxt     = period_q;
          steps_rem_nxt = steps_rem - CNT_W'(1);
          if (steps_rem == CNT_W'(1)) state_nxt = FINISH;
        end else begin
          timer_nxt = timer - PER_W'(1);
        end
        // A coincident step is still emitted; only later steps are dropped.
        if (abort_c) state_nxt = FINISH;
      end
      FINISH: begin
        timer_nxt     = '0;
        steps_rem_nxt = '0;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Ready stays low through the done cycle and returns one cycle later.
    cmd_ready_nxt = (state_nxt == IDLE) && (state != FINISH);
    busy_nxt      = (state_nxt == RUN);
    done_nxt      = (state == FINISH);
  end

  // Position update (preload wins over a coincident step) and index compare.
  always_comb begin
    position_nxt = position;
    if (preload_wen) begin
      position_nxt = preload_val;
    end else if (step_c) begin
      position_nxt = dir_q ? (position + CNT_W'(1)) : (position - CNT_W'(1));
    end
    enc_i_nxt = (index_cpr != '0) && (phase_nxt == PH_00) &&
                ((position_nxt % index_cpr) == '0);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      timer     <= '0;
      period_q  <= '0;
      steps_rem <= '0;
      dir_q     <= 1'b1;
      position  <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      enc_i     <= 1'b0;
    end else begin
      timer     <= timer_nxt;
      period_q  <= period_nxt;
      steps_rem <= steps_rem_nxt;
      dir_q     <= dir_nxt;
      position  <= position_nxt;
      cmd_ready <= cmd_ready_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      enc_i     <= enc_i_nxt;
    end
  end

endmodule
